// File: rtl/output_credit_arbiter_pkg.sv
// Shared types and helpers for the per-output-port credit arbiter.
package output_credit_arbiter_pkg;

  // Depth of one downstream virtual channel buffer, in flits.
  localparam int VC_SIZE = 8;

  typedef enum logic [1:0] {
    OA_IDLE   = 2'd0,
    OA_GRANT  = 2'd1,
    OA_LOCKED = 2'd2
  } oa_state_t;

  // Ceiling log2, never narrower than one bit so single-entry configs still elaborate.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/output_credit_arbiter_if.sv
// Handshake bundle between the input VCs and one output-port arbiter.
interface output_credit_arbiter_if
  import output_credit_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 8,
  parameter int CREDIT_MAX = VC_SIZE
);
  localparam int CNT_W = clog2(CREDIT_MAX + 1);
  localparam int IDX_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_head;
  logic [NUM_REQ-1:0] req_tail;
  logic               credit_in;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] credit_ok;
  logic               flit_sent;
  logic [IDX_W-1:0]   owner;
  logic               busy;
  logic [CNT_W-1:0]   credits;
  logic               credit_err;

  // VC side: presents head-of-buffer flits and credit returns, receives ownership and send enables.
  modport master (
    output req, req_head, req_tail, credit_in,
    input  grant, credit_ok, flit_sent, owner, busy, credits, credit_err
  );

  // Arbiter side.
  modport slave (
    input  req, req_head, req_tail, credit_in,
    output grant, credit_ok, flit_sent, owner, busy, credits, credit_err
  );

endinterface

// File: rtl/output_credit_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  // Scan N positions starting at ptr; modulo keeps non-power-of-2 N wrapping correctly.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    pos        = '0;
    for (int i = 0; i < N; i++) begin
      pos = IDX_W'((int'(ptr) + i) % N);
      if (!any && req[pos]) begin
        any             = 1'b1;
        gnt_idx         = pos;
        gnt_onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_credit_arbiter.sv
// Wormhole allocator for one output port: round-robin per packet, held until the tail,
// with a credit counter guarding the single downstream VC.
module output_credit_arbiter
  import output_credit_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 8,
  parameter int CREDIT_MAX = VC_SIZE
) (
  input logic                    clk,
  input logic                    rst,
  output_credit_arbiter_if.slave bus
);

  localparam int CNT_W = clog2(CREDIT_MAX + 1);
  localparam int IDX_W = clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CREDIT_FULL = CNT_W'(CREDIT_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

  oa_state_t          state, state_nxt;
  logic [IDX_W-1:0]   owner_q, owner_nxt;
  logic [NUM_REQ-1:0] owner_oh_q, owner_oh_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]   credits_q, credits_nxt;
  logic               credit_err_q, credit_err_nxt;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               owner_req;
  logic               owner_tail;
  logic               send;

  // Only packet-starting flits may win the port; body/tail flits wait for their own owner.
  assign cand       = bus.req & bus.req_head;
  assign owner_req  = |(bus.req & owner_oh_q);
  assign owner_tail = |(bus.req_tail & owner_oh_q);

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (cand),
    .ptr        (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any        (arb_any)
  );

  // Next-state logic: owner latched only on IDLE->GRANT so the crossbar select is packet-stable.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner_q;
    owner_oh_nxt = owner_oh_q;
    rr_ptr_nxt   = rr_ptr;
    send         = 1'b0;
    case (state)
      OA_IDLE: begin
        if (arb_any) begin
          owner_nxt    = arb_idx;
          owner_oh_nxt = arb_onehot;
          state_nxt    = OA_GRANT;
        end
      end
      OA_GRANT: begin
        state_nxt = OA_LOCKED;
      end
      OA_LOCKED: begin
        send = owner_req && (credits_q != '0);
        if (send && owner_tail) begin
          rr_ptr_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
          state_nxt  = OA_IDLE;
        end
      end
      default: begin
        state_nxt = OA_IDLE;
      end
    endcase
  end

  // Credit bookkeeping: a send and a return in the same cycle cancel; overflow is flagged, not stored.
  always_comb begin
    credits_nxt    = credits_q;
    credit_err_nxt = credit_err_q;
    case ({send, bus.credit_in})
      2'b10: credits_nxt = credits_q - CNT_W'(1);
      2'b01: begin
        if (credits_q == CREDIT_FULL) credit_err_nxt = 1'b1;
        else                          credits_nxt    = credits_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // State and counter registers; reset drops any in-flight packet and refills credits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= OA_IDLE;
      owner_q      <= '0;
      owner_oh_q   <= '0;
      rr_ptr       <= '0;
      credits_q    <= CREDIT_FULL;
      credit_err_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner_q      <= owner_nxt;
      owner_oh_q   <= owner_oh_nxt;
      rr_ptr       <= rr_ptr_nxt;
      credits_q    <= credits_nxt;
      credit_err_q <= credit_err_nxt;
    end
  end

  assign bus.grant      = (state == OA_GRANT) ? owner_oh_q : '0;
  assign bus.credit_ok  = send ? owner_oh_q : '0;
  assign bus.flit_sent  = send;
  assign bus.owner      = owner_q;
  assign bus.busy       = (state != OA_IDLE);
  assign bus.credits    = credits_q;
  assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_output_credit_arbiter.sv
// Directed bench for output_credit_arbiter with a grant/flit scoreboard on the 8-credit instance
// and a cycle table for a 2-credit instance.
`timescale 1ns/1ps
module tb_output_credit_arbiter;
  import output_credit_arbiter_pkg::*;

  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_credit_arbiter_if #(.NUM_REQ(NR), .CREDIT_MAX(8)) bus8 ();
  output_credit_arbiter_if #(.NUM_REQ(NR), .CREDIT_MAX(2)) bus2 ();

  output_credit_arbiter #(.NUM_REQ(NR), .CREDIT_MAX(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  output_credit_arbiter #(.NUM_REQ(NR), .CREDIT_MAX(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int errors = 0;
  int checks = 0;

  int exp_grant_q[$];
  int exp_flit_q[$];
  int mon_exp;

  int pkt_len [NR];
  int sent_cnt[NR];
  int hold_at [NR];
  logic [NR-1:0] last_ok = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int r, input int len);
    pkt_len[r]  = len;
    sent_cnt[r] = 0;
  endtask

  task automatic expectPacket(input int r, input int flits);
    exp_grant_q.push_back(r);
    for (int i = 0; i < flits; i++) exp_flit_q.push_back(r);
  endtask

  task automatic waitSent(input int r, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (sent_cnt[r] < n && cyc < budget) begin
      nextCycle();
      cyc++;
    end
    checkOutput($sformatf("done_vc%0d", r), 32'(sent_cnt[r] >= n), 32'd1);
  endtask

  task automatic returnCredits(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      bus8.credit_in = 1'b1;
    end
    nextCycle();
    bus8.credit_in = 1'b0;
  endtask

  // VC model for the 8-credit instance: advances each VC past flits the DUT committed last cycle.
  initial begin
    logic [NR-1:0] r_req, r_head, r_tail;
    forever begin
      @(posedge clk);
      #3;
      for (int r = 0; r < NR; r++) begin
        if (last_ok[r]) sent_cnt[r]++;
        r_req[r]  = (sent_cnt[r] < pkt_len[r]) && (sent_cnt[r] != hold_at[r]);
        r_head[r] = (sent_cnt[r] == 0);
        r_tail[r] = (sent_cnt[r] == pkt_len[r] - 1);
      end
      bus8.req      = r_req;
      bus8.req_head = r_head;
      bus8.req_tail = r_tail;
    end
  end

  // Scoreboard monitor: every grant and every sent flit must match the next expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      last_ok = bus8.credit_ok;
      if (!rst) begin
        if (bus8.grant != '0) begin
          if (exp_grant_q.size() == 0) checkOutput("grant_unexpected", 32'(bus8.grant), 32'd0);
          else begin
            mon_exp = exp_grant_q.pop_front();
            checkOutput("grant_order", 32'(bus8.grant), 32'd1 << mon_exp);
          end
        end
        if (bus8.flit_sent) begin
          if (exp_flit_q.size() == 0) checkOutput("flit_unexpected", 32'(bus8.credit_ok), 32'd0);
          else begin
            mon_exp = exp_flit_q.pop_front();
            checkOutput("flit_owner", 32'(bus8.owner), 32'(mon_exp));
            checkOutput("flit_ok", 32'(bus8.credit_ok), 32'd1 << mon_exp);
          end
        end
      end
    end
  end

  initial begin
    logic [12:0] t4_cin, t4_ok, t4_busy, t4_grant;
    int t4_cred[13];
    int sent2;

    bus8.req = '0; bus8.req_head = '0; bus8.req_tail = '0; bus8.credit_in = 1'b0;
    bus2.req = '0; bus2.req_head = '0; bus2.req_tail = '0; bus2.credit_in = 1'b0;
    for (int r = 0; r < NR; r++) begin
      pkt_len[r] = 0; sent_cnt[r] = 0; hold_at[r] = 255;
    end

    rst = 1'b1;
    repeat (3) nextCycle();
    rst = 1'b0;

    // 1: idle after reset
    repeat (10) begin
      nextCycle();
      checkOutput("idle_credits", 32'(bus8.credits), 32'd8);
      checkOutput("idle_flags", 32'({bus8.busy, bus8.credit_err, bus8.grant}), 32'd0);
    end
    $display("[TB] idle checks done");

    // 2: single 4-flit packet on VC2
    expectPacket(2, 4);
    applyStimulus(2, 4);
    nextCycle();
    checkOutput("t2_no_grant_yet", 32'({bus8.busy, bus8.grant}), 32'd0);
    nextCycle();
    checkOutput("t2_grant", 32'(bus8.grant), 32'h04);
    checkOutput("t2_owner", 32'(bus8.owner), 32'd2);
    checkOutput("t2_grant_no_ok", 32'(bus8.credit_ok), 32'd0);
    nextCycle();
    checkOutput("t2_first_ok", 32'(bus8.credit_ok), 32'h04);
    waitSent(2, 4, 20);
    nextCycle();
    checkOutput("t2_credits", 32'(bus8.credits), 32'd4);
    checkOutput("t2_idle", 32'(bus8.busy), 32'd0);
    returnCredits(4);
    checkOutput("t2_refill", 32'(bus8.credits), 32'd8);

    // 3: VC1 and VC5 heads together, pointer at 3 -> VC5 whole packet, then VC1
    expectPacket(5, 3);
    expectPacket(1, 3);
    applyStimulus(1, 3);
    applyStimulus(5, 3);
    waitSent(1, 3, 40);
    nextCycle();
    checkOutput("t3_credits", 32'(bus8.credits), 32'd2);
    checkOutput("t3_idle", 32'(bus8.busy), 32'd0);
    returnCredits(6);
    checkOutput("t3_refill", 32'(bus8.credits), 32'd8);
    checkOutput("t3_no_err", 32'(bus8.credit_err), 32'd0);

    // 5: credit return while already full
    nextCycle();
    bus8.credit_in = 1'b1;
    nextCycle();
    bus8.credit_in = 1'b0;
    checkOutput("t5_credits_hold", 32'(bus8.credits), 32'd8);
    checkOutput("t5_err_set", 32'(bus8.credit_err), 32'd1);
    repeat (5) nextCycle();
    checkOutput("t5_err_sticky", 32'(bus8.credit_err), 32'd1);

    // 4: two-credit instance, 5-flit packet on VC0 driven from a cycle table
    t4_cin   = 13'b0111100100000;
    t4_ok    = 13'b0011001001100;
    t4_busy  = 13'b0011111111110;
    t4_grant = 13'b0000000000010;
    t4_cred  = '{2, 2, 2, 1, 0, 0, 1, 0, 0, 1, 1, 1, 2};
    sent2 = 0;
    for (int c = 0; c < 13; c++) begin
      nextCycle();
      if (c > 0 && t4_ok[c-1]) sent2++;
      bus2.req       = {7'b0, (sent2 < 5)};
      bus2.req_head  = {7'b0, (sent2 == 0)};
      bus2.req_tail  = {7'b0, (sent2 == 4)};
      bus2.credit_in = t4_cin[c];
      #1;
      checkOutput($sformatf("t4_ok_c%0d", c), 32'(bus2.credit_ok), 32'(t4_ok[c]));
      checkOutput($sformatf("t4_credits_c%0d", c), 32'(bus2.credits), 32'(t4_cred[c]));
      checkOutput($sformatf("t4_busy_c%0d", c), 32'(bus2.busy), 32'(t4_busy[c]));
      checkOutput($sformatf("t4_grant_c%0d", c), 32'(bus2.grant), 32'(t4_grant[c]));
    end
    nextCycle();
    bus2.req = '0; bus2.req_head = '0; bus2.req_tail = '0; bus2.credit_in = 1'b0;
    checkOutput("t4_no_err", 32'(bus2.credit_err), 32'd0);

    // 6: owner stalls mid-packet, then reset while LOCKED
    hold_at[6] = 2;
    expectPacket(6, 2);
    applyStimulus(6, 4);
    waitSent(6, 2, 20);
    repeat (3) nextCycle();
    checkOutput("t6_stall_busy", 32'(bus8.busy), 32'd1);
    checkOutput("t6_stall_ok", 32'(bus8.credit_ok), 32'd0);
    checkOutput("t6_stall_credits", 32'(bus8.credits), 32'd6);
    checkOutput("t6_stall_owner", 32'(bus8.owner), 32'd6);
    rst = 1'b1;
    nextCycle();
    checkOutput("t6_rst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("t6_rst_credits", 32'(bus8.credits), 32'd8);
    checkOutput("t6_rst_grant", 32'(bus8.grant), 32'd0);
    checkOutput("t6_rst_err", 32'(bus8.credit_err), 32'd0);
    for (int r = 0; r < NR; r++) begin
      pkt_len[r] = 0; sent_cnt[r] = 0; hold_at[r] = 255;
    end
    rst = 1'b0;
    expectPacket(1, 1);
    expectPacket(3, 1);
    applyStimulus(1, 1);
    applyStimulus(3, 1);
    waitSent(3, 1, 30);
    nextCycle();
    checkOutput("t6_after_credits", 32'(bus8.credits), 32'd6);
    checkOutput("t6_after_idle", 32'(bus8.busy), 32'd0);
    checkOutput("sb_grants_left", 32'(exp_grant_q.size()), 32'd0);
    checkOutput("sb_flits_left", 32'(exp_flit_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
